// File: rtl/baud_pkg.sv
// Shared widths, divisor record and elaboration-time helpers for the programmable baud generator.
// BAUD_FRAC_EN enables the fractional divisor; without it every divisor has a zero frac field.
package baud_pkg;

    localparam int BAUD_DIV_W  = 12;
    localparam int BAUD_FRAC_W = 4;

`ifdef BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    typedef struct packed {
        logic [BAUD_DIV_W-1:0]  ip;
        logic [BAUD_FRAC_W-1:0] fp;
    } div_t;

    function automatic bit os_legal(int os);
        return (os >= 4) && (os <= 32);
    endfunction

    // Base-tick divisor rounded to the nearest 1/2^FRAC_W clock (or whole clock without fractions).
    function automatic div_t reset_div(longint clk_hz, longint baud, longint os);
        longint den;
        longint r;
        div_t   d;
        den = baud * os;
        if (FRAC_ON) begin
            r    = ((clk_hz << BAUD_FRAC_W) + den / 2) / den;
            d.ip = BAUD_DIV_W'(r >> BAUD_FRAC_W);
            d.fp = BAUD_FRAC_W'(r);
        end else begin
            r    = (clk_hz + den / 2) / den;
            d.ip = BAUD_DIV_W'(r);
            d.fp = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/baud_gen_prog_if.sv
// Control/enable bundle between the UART register block, the baud generator and the Tx/Rx engines.
interface baud_gen_prog_if #(
    parameter int DIV_W  = baud_pkg::BAUD_DIV_W,
    parameter int FRAC_W = baud_pkg::BAUD_FRAC_W
);
    logic                    rx_allowed;
    logic                    rx_resync;
    logic                    tx_enable;
    logic [DIV_W-1:0]        div_int;
    logic [FRAC_W-1:0]       div_frac;
    logic                    div_load;
    logic                    rxclk_en;
    logic                    txclk_en;
    logic                    div_pending;
    logic [DIV_W+FRAC_W-1:0] div_active;

    modport master (
        output rx_allowed, rx_resync, tx_enable, div_int, div_frac, div_load,
        input  rxclk_en, txclk_en, div_pending, div_active
    );

    modport slave (
        input  rx_allowed, rx_resync, tx_enable, div_int, div_frac, div_load,
        output rxclk_en, txclk_en, div_pending, div_active
    );
endinterface

// File: rtl/baud_prescaler.sv
// Down-counting base-tick prescaler with optional fractional carry (BAUD_FRAC_EN).
// fire is the combinational reload condition; tick is its registered one-cycle pulse.
module baud_prescaler import baud_pkg::*; #(
    parameter int DIV_W  = BAUD_DIV_W,
    parameter int FRAC_W = BAUD_FRAC_W
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              restart,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              fire,
    output logic              tick
);
    logic [DIV_W-1:0] cnt;
    logic             carry;

    assign fire = !hold && !restart && (cnt == '0);

    // Reload to P-1 where P = div_int + carry.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= fire;
            if (hold)         cnt <= '0;
            else if (restart) cnt <= div_int - DIV_W'(1);
            else if (fire)    cnt <= carry ? div_int : div_int - DIV_W'(1);
            else              cnt <= cnt - DIV_W'(1);
        end
    end

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, div_frac};
    assign carry = sum[FRAC_W];

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n)                acc <= '0;
        else if (hold || restart)  acc <= '0;
        else if (fire)             acc <= sum[FRAC_W-1:0];
    end
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
    assign carry       = 1'b0;
`endif

endmodule

// File: rtl/baud_gen_prog.sv
// Programmable UART baud generator: Tx bit enable and Rx oversample enable from one runtime divisor.
// Fractional divisor support is compiled in with BAUD_FRAC_EN.
module baud_gen_prog import baud_pkg::*; #(
    parameter int CLK_HZ       = 50000000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = BAUD_DIV_W,
    parameter int FRAC_W       = BAUD_FRAC_W
) (
    input  logic           clk_50m,
    input  logic           rst_n,
    baud_gen_prog_if.slave bif
);
    localparam int   SUB_W   = $clog2(OVERSAMPLE);
    localparam div_t DIV_RST = reset_div(CLK_HZ, DEFAULT_BAUD, OVERSAMPLE);

    if (!os_legal(OVERSAMPLE) || DIV_W != BAUD_DIV_W || FRAC_W != BAUD_FRAC_W) begin : g_bad_cfg
        $error("baud_gen_prog: OVERSAMPLE must be 4..32 and divisor widths must match baud_pkg");
    end

    div_t             div_act, div_pend, div_use, div_cap;
    logic             pending, apply;
    logic             tx_fire, tx_tick, tx_bit_q;
    logic             rx_fire, rx_tick;
    logic [SUB_W-1:0] sub;

    always_comb begin
        div_cap.ip = (bif.div_int < DIV_W'(2)) ? DIV_W'(2) : bif.div_int;
        div_cap.fp = FRAC_ON ? bif.div_frac : '0;
    end

    // New divisor takes effect on the reload that starts a Tx bit, so both prescalers see it at once.
    assign apply   = pending && ((tx_fire && sub == '0) || !bif.tx_enable);
    assign div_use = apply ? div_pend : div_act;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            div_act  <= DIV_RST;
            div_pend <= DIV_RST;
            pending  <= 1'b0;
        end else begin
            if (apply) div_act <= div_pend;
            if (bif.div_load) begin
                div_pend <= div_cap;
                pending  <= 1'b1;
            end else if (apply) begin
                pending  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sub      <= '0;
            tx_bit_q <= 1'b0;
        end else if (!bif.tx_enable) begin
            sub      <= '0;
            tx_bit_q <= 1'b0;
        end else if (tx_fire) begin
            tx_bit_q <= (sub == '0);
            sub      <= (sub == SUB_W'(OVERSAMPLE - 1)) ? '0 : sub + SUB_W'(1);
        end
    end

    baud_prescaler #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_tx_pre (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .hold     (!bif.tx_enable),
        .restart  (1'b0),
        .div_int  (div_use.ip),
        .div_frac (div_use.fp),
        .fire     (tx_fire),
        .tick     (tx_tick)
    );

    baud_prescaler #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_rx_pre (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .hold     (1'b0),
        .restart  (bif.rx_resync || apply),
        .div_int  (div_use.ip),
        .div_frac (div_use.fp),
        .fire     (rx_fire),
        .tick     (rx_tick)
    );

    logic unused_rx_fire;
    assign unused_rx_fire = rx_fire;

    assign bif.rxclk_en    = rx_tick & bif.rx_allowed;
    assign bif.txclk_en    = tx_tick & tx_bit_q;
    assign bif.div_pending = pending;
    assign bif.div_active  = div_act;

endmodule

// File: doc/baud_gen_prog.md
Name: baud_gen_prog

Overview:
- Programmable successor to the fixed 115200-baud generator for the UART Tx/Rx pair.
- Produces a Tx bit-rate enable and an Rx oversample enable. Both come from a runtime-loadable divisor with an optional fractional part, so non-integer clock/baud ratios keep low long-term error.
- Adds three behaviours: Rx phase resync on start-edge, a glitch-free divisor change at Tx bit boundaries, and Tx gating.
- Sits between the UART control registers and the uart_tx/uart_rx engines.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- DEFAULT_BAUD, 115200, baud rate after reset.
- OVERSAMPLE, 16, Rx enables per bit; also the Tx bit period in base ticks. Legal range 4..32.
- DIV_W, 12, width of the integer divisor (base tick period in clocks).
- FRAC_W, 4, width of the fractional divisor (units of 1/2^FRAC_W clock).

Ports:
- clk_50m  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_allowed  in  1  gates rxclk_en; the counters keep running while low
- rx_resync  in  1  one-cycle pulse from the Rx engine on start-bit edge; restarts Rx phase
- tx_enable  in  1  low holds the Tx prescaler idle
- div_int  in  DIV_W  new integer divisor
- div_frac  in  FRAC_W  new fractional divisor
- div_load  in  1  one-cycle strobe capturing div_int/div_frac
- rxclk_en  out  1  one-cycle Rx oversample enable
- txclk_en  out  1  one-cycle Tx bit enable
- div_pending  out  1  a loaded divisor is waiting to apply
- div_active  out  DIV_W+FRAC_W  divisor in use, {int,frac}

Behaviour:
- Reset values:
  - rxclk_en=0, txclk_en=0, div_pending=0.
  - All counters and fractional accumulators = 0.
  - div_active = round(CLK_HZ*2^FRAC_W/(DEFAULT_BAUD*OVERSAMPLE)) = {27,2} for the defaults.
- Prescaler (one per direction, identical):
  - cnt counts down.
  - When cnt==0: reload cnt=P-1 and assert tick registered for one cycle. P = div_int_active + carry.
  - carry is the carry-out of acc+div_frac_active (FRAC_W-bit wrap); acc updates on every reload.
  - Otherwise cnt decrements. The first tick is registered on the first clock edge after reset release.
- Rx path:
  - rxclk_en = Rx tick AND rx_allowed.
  - rx_resync forces cnt=div_int_active-1 and acc=0, with no tick that cycle. Resync wins over a simultaneous cnt==0.
- Tx path:
  - A sub-counter counts Tx base ticks modulo OVERSAMPLE.
  - txclk_en is asserted in the cycle the base tick coincides with sub==0.
  - tx_enable=0 holds cnt, acc and sub at 0 with txclk_en=0. On the cycle tx_enable rises, the first txclk_en is registered at the next edge.
- Tx bit period = OVERSAMPLE*div_int + (number of carries). Defaults give 16*27+2 = 434 clocks.
- Divisor load:
  - div_load captures the inputs into a pending register and sets div_pending.
  - The pending value applies in the same cycle txclk_en is generated, or on the next cycle if tx_enable=0.
  - On apply, div_pending clears and the Rx prescaler restarts exactly as for rx_resync.
  - A second div_load while pending overwrites the pending value.
  - div_load coincident with apply: the new value goes to pending; the old pending value applies.
- Width/boundary rules:
  - div_int < 2 is clamped to 2 on capture.
  - Counters are DIV_W bits.
  - The accumulator wraps silently.
  - The sub-counter is $clog2(OVERSAMPLE) bits and wraps at OVERSAMPLE-1.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and any pending divisor is discarded.

Optional Feature:
- Macro: BAUD_FRAC_EN.
- Defined: fractional accumulators are present and div_frac is honoured, as described above.
- Undefined:
  - No accumulators; carry=0 always.
  - div_frac is ignored; the frac field of div_active reads 0.
  - The reset divisor is the integer round of CLK_HZ/(DEFAULT_BAUD*OVERSAMPLE) = 27.
  - Tx bit period = 432 clocks at the defaults.

Decomposition:
- Package baud_pkg:
  - reset-divisor computation (constant function);
  - OVERSAMPLE legal-range check;
  - divisor struct/field widths.
- Sub-module baud_prescaler:
  - contains cnt, the optional accumulator and the tick register;
  - inputs: restart and hold;
  - instantiated twice, once for Tx base and once for Rx.

Test Plan:
- Reset, defaults, tx_enable=1, rx_allowed=1, BAUD_FRAC_EN defined -> rxclk_en every 27 or 28 clocks, exactly 2 of 28 in every 16 ticks; txclk_en spacing exactly 434 clocks over 10 bits.
- Same bench with BAUD_FRAC_EN undefined -> rxclk_en period 27; txclk_en period 432.
- div_load {int=3,frac=0} mid-bit -> div_pending=1 until the next txclk_en; thereafter txclk_en period 48 and rxclk_en period 3; div_active={3,0}.
- rx_resync asserted in the same cycle the Rx cnt reaches 0 -> no rxclk_en that cycle; next rxclk_en exactly div_int clocks later; Tx timing unaffected.
- rx_allowed=0 for 100 clocks -> no rxclk_en; on re-enable, the phase is consistent with a free-running counter.
- tx_enable toggled 0->1, rst_n pulsed low mid-bit with div_pending=1 -> txclk_en at the first edge after enable; after reset, div_pending=0 and div_active={27,2}.
